// File: rtl/bus_memory.sv
// bus_memory: wait-stated 64-bit word memory behind a strobed CPU address/data bus.
// Defining MEM_TAG_EN adds an 8-bit tag stored with every word and returned on o_tag.
module bus_memory #(
  parameter int ADDR_W = 12,
  parameter int WAIT   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] i_ad,
  input  logic [7:0]  i_tag,
  input  logic        i_astb,
  input  logic        i_rd,
  input  logic        i_wr,
  output logic [63:0] o_data,
  output logic [7:0]  o_tag,
  output logic        o_busy,
  output logic        o_err
);
  typedef enum logic [1:0] {IDLE, WAITING, DONE} state_t;
  state_t r_state, w_next;
  logic [19:0] r_addr;
  logic [2:0] r_cnt;
  logic r_is_wr;
  logic [63:0] r_wdata;
  logic [63:0] r_mem [2**ADDR_W];
  logic w_start, w_range_err, w_mem_we, w_err;
  logic [ADDR_W-1:0] w_idx;
  assign w_start     = r_state == IDLE && !i_astb && (i_rd ^ i_wr);
  assign w_range_err = (r_addr >> ADDR_W) != '0;
  assign w_idx       = r_addr[ADDR_W-1:0];
  assign w_mem_we    = !reset && r_state == DONE && r_is_wr && !w_range_err;
  assign o_busy      = r_state != IDLE;
  // Strobes during an access, dual requests and out-of-range completions all latch the sticky flag.
  assign w_err = (r_state == IDLE && !i_astb && i_rd && i_wr) ||
                 (r_state != IDLE && (i_astb || i_rd || i_wr)) ||
                 (r_state == DONE && w_range_err);
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE    ? (w_start ? (WAIT == 0 ? DONE : WAITING) : IDLE) :
             r_state == WAITING ? (r_cnt == 3'd0 ? DONE : WAITING) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_is_wr <= 1'b0;
      r_wdata <= '0;
      o_data  <= '0;
      o_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && i_astb) r_addr <= i_ad[19:0];
      if (w_start) begin
        r_cnt   <= 3'(WAIT);
        r_is_wr <= i_wr;
        r_wdata <= i_ad;
      end else if (r_state == WAITING && r_cnt != 3'd0) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (r_state == DONE) begin
        r_addr <= r_addr + 20'd1;
        if (!r_is_wr) o_data <= w_range_err ? '0 : r_mem[w_idx];
      end
      if (w_err) o_err <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_idx] <= r_wdata;
  end
`ifdef MEM_TAG_EN
  logic [7:0] r_wtag;
  logic [7:0] r_mem_tag [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wtag <= '0;
      o_tag  <= '0;
    end else begin
      if (w_start) r_wtag <= i_tag;
      if (r_state == DONE && !r_is_wr) o_tag <= w_range_err ? '0 : r_mem_tag[w_idx];
    end
  end
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem_tag[w_idx] <= r_wtag;
  end
`else
  logic w_unused_tag;
  assign w_unused_tag = ^i_tag;
  assign o_tag = '0;
`endif
endmodule

// File: tb/tb_bus_memory.sv
// tb_bus_memory: vector table, directed corner sequences and a random run against a word-level memory model.
module tb_bus_memory;
`ifdef MEM_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif
  localparam int AW = 12;
  logic clk = 1'b0, reset = 1'b0;
  logic [63:0] i_ad = '0, a3 = '0;
  logic [7:0] i_tag = '0, tg3 = '0;
  logic i_astb = 1'b0, i_rd = 1'b0, i_wr = 1'b0;
  logic astb3 = 1'b0, rd3 = 1'b0, wr3 = 1'b0;
  logic [63:0] o_data, d3;
  logic [7:0] o_tag, t3;
  logic o_busy, o_err, b3, e3;
  int total = 0, bad = 0;
  bus_memory #(.ADDR_W(AW), .WAIT(1)) dut (
    .clk(clk), .reset(reset), .i_ad(i_ad), .i_tag(i_tag), .i_astb(i_astb), .i_rd(i_rd), .i_wr(i_wr),
    .o_data(o_data), .o_tag(o_tag), .o_busy(o_busy), .o_err(o_err));
  bus_memory #(.ADDR_W(AW), .WAIT(3)) dut3 (
    .clk(clk), .reset(reset), .i_ad(a3), .i_tag(tg3), .i_astb(astb3), .i_rd(rd3), .i_wr(wr3),
    .o_data(d3), .o_tag(t3), .o_busy(b3), .o_err(e3));
  always #5 clk = ~clk;
  typedef struct {
    logic [19:0] addr;
    logic [63:0] data;
    logic [7:0]  tag;
    logic [63:0] exp_data;
    logic [7:0]  exp_tag;
    logic        exp_err;
  } vec_t;
  vec_t vecs [6];
  logic [63:0] m_data [2**AW];
  logic [7:0]  m_tag  [2**AW];
  bit          m_known[2**AW];
  logic [19:0] m_addr;
  bit m_err, e_known;
  logic [63:0] e_data;
  logic [7:0]  e_tag;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 20 && o_busy; i++) cyc();
    chk("idle_timeout", o_busy, 0);
  endtask
  task automatic do_astb(input logic [19:0] a);
    i_ad = {44'h0, a};
    i_astb = 1'b1;
    cyc();
    i_astb = 1'b0;
  endtask
  task automatic do_wr(input logic [63:0] d, input logic [7:0] t);
    i_ad = d;
    i_tag = t;
    i_wr = 1'b1;
    cyc();
    i_wr = 1'b0;
    wait_idle();
  endtask
  task automatic do_rd();
    i_rd = 1'b1;
    cyc();
    i_rd = 1'b0;
    wait_idle();
  endtask
  task automatic rand_op(input int op);
    logic [63:0] d;
    logic [7:0] t;
    int r;
    d = {$urandom, $urandom};
    t = 8'($urandom);
    if (op <= 1) begin
      r = $urandom_range(0, 3);
      m_addr = r == 0 ? 20'($urandom_range(0, 31)) :
               r == 1 ? 20'($urandom_range(4090, 4095)) :
               r == 2 ? 20'h01000 | 20'($urandom_range(0, 20'hFEFFF)) : 20'($urandom_range(20'hFFFFE, 20'hFFFFF));
      do_astb(m_addr);
    end else if (op <= 5) begin
      do_wr(d, t);
      if (m_addr < 2**AW) begin
        m_data[m_addr] = d;
        m_tag[m_addr] = TAG_EN ? t : 8'h00;
        m_known[m_addr] = 1'b1;
      end else m_err = 1'b1;
      m_addr = m_addr + 20'd1;
    end else if (op <= 8) begin
      do_rd();
      if (m_addr < 2**AW) begin
        e_known = m_known[m_addr];
        e_data = m_data[m_addr];
        e_tag = m_tag[m_addr];
      end else begin
        e_known = 1'b1;
        e_data = '0;
        e_tag = '0;
        m_err = 1'b1;
      end
      m_addr = m_addr + 20'd1;
      if (e_known) begin
        chk("rand_data", o_data, e_data);
        chk("rand_tag", {56'h0, o_tag}, {56'h0, e_tag});
      end
    end else begin
      i_ad = d;
      i_rd = 1'b1;
      i_wr = 1'b1;
      cyc();
      i_rd = 1'b0;
      i_wr = 1'b0;
      chk("rand_dual_busy", o_busy, 0);
      m_err = 1'b1;
    end
    chk("rand_err", o_err, m_err);
  endtask
  initial begin
    vecs[0] = '{20'h00000, 64'h1111_2222_3333_4444, 8'h11, 64'h1111_2222_3333_4444, TAG_EN ? 8'h11 : 8'h00, 1'b0};
    vecs[1] = '{20'h00FFF, 64'hFFFF_0000_FFFF_0000, 8'hFF, 64'hFFFF_0000_FFFF_0000, TAG_EN ? 8'hFF : 8'h00, 1'b0};
    vecs[2] = '{20'h00123, 64'hDEAD_BEEF_CAFE_F00D, 8'h5A, 64'hDEAD_BEEF_CAFE_F00D, TAG_EN ? 8'h5A : 8'h00, 1'b0};
    vecs[3] = '{20'h00800, 64'h8000_0000_0000_0001, 8'h80, 64'h8000_0000_0000_0001, TAG_EN ? 8'h80 : 8'h00, 1'b0};
    vecs[4] = '{20'h01000, 64'h7777_7777_7777_7777, 8'h77, 64'h0, 8'h00, 1'b1};
    vecs[5] = '{20'hFFFFF, 64'h9999_9999_9999_9999, 8'h99, 64'h0, 8'h00, 1'b1};
    do_reset();
    chk("rst_data", o_data, 0);
    chk("rst_tag", {56'h0, o_tag}, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_err", o_err, 0);
    chk("rst3_busy", b3, 0);
    chk("rst3_data", d3, 0);
    // write then read at 0x10 with exact latency
    do_astb(20'h10);
    do_wr(64'h0123456789ABCDEF, 8'h05);
    chk("wr_keeps_data", o_data, 0);
    do_astb(20'h10);
    i_rd = 1'b1;
    cyc();
    i_rd = 1'b0;
    chk("rd_busy1", o_busy, 1);
    cyc();
    cyc();
    chk("rd_busy2", o_busy, 1);
    chk("rd_not_early", o_data, 0);
    cyc();
    chk("rd_busy_done", o_busy, 0);
    chk("rd_data", o_data, 64'h0123456789ABCDEF);
    chk("rd_tag", {56'h0, o_tag}, TAG_EN ? 64'h05 : 64'h0);
    chk("rd_err", o_err, 0);
    // auto-increment
    do_astb(20'h7);
    do_wr(64'hAAAA_AAAA_0000_0007, 8'hA7);
    do_wr(64'hBBBB_BBBB_0000_0008, 8'hB8);
    chk("inc_wr_keeps_data", o_data, 64'h0123456789ABCDEF);
    do_astb(20'h8);
    do_rd();
    chk("inc_data", o_data, 64'hBBBB_BBBB_0000_0008);
    do_astb(20'h7);
    do_rd();
    do_rd();
    chk("inc_rd_seq", o_data, 64'hBBBB_BBBB_0000_0008);
    // vector table
    for (int i = 0; i < 6; i++) begin
      do_astb(vecs[i].addr);
      do_wr(vecs[i].data, vecs[i].tag);
      do_astb(vecs[i].addr);
      do_rd();
      chk($sformatf("vec%0d_data", i), o_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_tag", i), {56'h0, o_tag}, {56'h0, vecs[i].exp_tag});
      chk($sformatf("vec%0d_err", i), o_err, vecs[i].exp_err);
    end
    // simultaneous rd and wr
    do_reset();
    chk("rst_clears_err", o_err, 0);
    do_astb(20'h10);
    i_ad = 64'h5555_5555_5555_5555;
    i_rd = 1'b1;
    i_wr = 1'b1;
    cyc();
    i_rd = 1'b0;
    i_wr = 1'b0;
    chk("dual_busy", o_busy, 0);
    chk("dual_err", o_err, 1);
    cyc();
    chk("dual_busy_later", o_busy, 0);
    do_rd();
    chk("dual_old_data", o_data, 64'h0123456789ABCDEF);
    // busy violation
    do_reset();
    do_astb(20'h8);
    i_rd = 1'b1;
    cyc();
    i_rd = 1'b0;
    cyc();
    i_rd = 1'b1;
    cyc();
    i_rd = 1'b0;
    cyc();
    chk("viol_busy", o_busy, 0);
    chk("viol_data", o_data, 64'hBBBB_BBBB_0000_0008);
    chk("viol_err", o_err, 1);
    cyc();
    chk("viol_no_second", o_busy, 0);
    // range error
    do_reset();
    do_astb(20'h10);
    do_rd();
    chk("range_pre_err", o_err, 0);
    do_astb(20'h1000);
    i_rd = 1'b1;
    cyc();
    i_rd = 1'b0;
    cyc();
    cyc();
    chk("range_busy", o_busy, 1);
    cyc();
    chk("range_busy_low", o_busy, 0);
    chk("range_data", o_data, 0);
    chk("range_tag", {56'h0, o_tag}, 0);
    chk("range_err", o_err, 1);
    // mid-access reset on the WAIT=3 instance
    a3 = 64'h20;
    astb3 = 1'b1;
    cyc();
    astb3 = 1'b0;
    a3 = 64'hC0FF_EE00_1234_5678;
    tg3 = 8'h3C;
    wr3 = 1'b1;
    cyc();
    wr3 = 1'b0;
    repeat (6) cyc();
    a3 = 64'h20;
    astb3 = 1'b1;
    cyc();
    astb3 = 1'b0;
    rd3 = 1'b1;
    cyc();
    rd3 = 1'b0;
    repeat (6) cyc();
    chk("w3_data", d3, 64'hC0FF_EE00_1234_5678);
    rd3 = 1'b1;
    wr3 = 1'b1;
    cyc();
    rd3 = 1'b0;
    wr3 = 1'b0;
    chk("w3_err", e3, 1);
    a3 = 64'h20;
    astb3 = 1'b1;
    cyc();
    astb3 = 1'b0;
    a3 = 64'h0BAD_0BAD_0BAD_0BAD;
    tg3 = 8'hE1;
    wr3 = 1'b1;
    cyc();
    wr3 = 1'b0;
    cyc();
    chk("w3_busy_waiting", b3, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("w3_rst_data", d3, 0);
    chk("w3_rst_tag", {56'h0, t3}, 0);
    chk("w3_rst_busy", b3, 0);
    chk("w3_rst_err", e3, 0);
    repeat (6) cyc();
    chk("w3_stays_idle", b3, 0);
    a3 = 64'h20;
    astb3 = 1'b1;
    cyc();
    astb3 = 1'b0;
    rd3 = 1'b1;
    cyc();
    rd3 = 1'b0;
    repeat (6) cyc();
    chk("w3_prior_data", d3, 64'hC0FF_EE00_1234_5678);
    chk("w3_prior_tag", {56'h0, t3}, TAG_EN ? 64'h3C : 64'h0);
    // randomized run against the model
    do_reset();
    for (int i = 0; i < 2**AW; i++) m_known[i] = 1'b0;
    m_addr = '0;
    m_err = 1'b0;
    for (int i = 0; i < 32; i++) rand_op(2);
    for (int i = 0; i < 400; i++) rand_op($urandom_range(0, 9));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
